// File: rtl/cs_pkg.sv
// Shared constants and state type for the approximate-average sequence controller.
package cs_pkg;

  localparam int N  = 9;   // window length in samples
  localparam int DW = 8;   // sample width
  localparam int OW = 10;  // result width
  localparam int SW = 12;  // running-sum width

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AVG    = 3'd1,
    SEARCH = 3'd2,
    CALC   = 3'd3,
    OUT    = 3'd4
  } cs_state_t;

endpackage

// File: rtl/cs_div9.sv
// Exact floor division of the 12-bit window sum by 9 (purely combinational).
module cs_div9
  import cs_pkg::*;
(
  input  logic [SW-1:0] din,
  output logic [8:0]    q
);

  logic [SW-1:0] q_full;

  // 4095 / 9 = 455, so the quotient always fits in 9 bits.
  assign q_full = din / SW'(9);
  assign q      = q_full[8:0];

endmodule

// File: rtl/cs_seq_ctrl.sv
// Sequence controller: fills an N-sample window, then per accepted sample computes
// y = (9*appr + sum) >> 3, where appr is the largest window value not above floor(sum/9).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is 1 only in IDLE; y_valid is 1 only in OUT and y_data is held until y_ready.
module cs_seq_ctrl #(
  parameter int N  = cs_pkg::N,
  parameter int DW = cs_pkg::DW,
  parameter int OW = cs_pkg::OW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic                win_shift,
  output logic [3:0]          rd_idx,
  input  logic [DW-1:0]       rd_data,
  input  logic [cs_pkg::SW-1:0] sum_in,
  output logic                y_valid,
  input  logic                y_ready,
  output logic [OW-1:0]       y_data,
  output logic                busy
);

  import cs_pkg::*;

  localparam logic [3:0] NL = 4'(N);

  cs_state_t     state;
  logic [3:0]    fcnt;
  logic [3:0]    sidx;
  logic [DW-1:0] appr;
  logic [8:0]    avg_reg;
  logic [SW-1:0] sum_reg;
  logic [OW-1:0] y_reg;
  logic [8:0]    avg_next;
  logic          accept;
  logic          cand_ok;
  logic [12:0]   calc;
  logic [12:0]   calc_sh;

  cs_div9 u_div9 (
    .din (sum_in),
    .q   (avg_next)
  );

  // Output decodes straight from the state register.
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign win_shift = accept;
  assign busy      = (state != IDLE);
  assign y_valid   = (state == OUT);
  assign y_data    = y_reg;
  assign rd_idx    = (state == SEARCH) ? sidx : 4'd0;

  // Candidate must not exceed the average and must beat the current best;
  // strict '>' keeps the earlier index on a tie.
  assign cand_ok = (SW'(rd_data) <= SW'(avg_reg)) && (rd_data > appr);

  // 13-bit intermediate: 9*255 + 2295 = 4590 at most.
  assign calc    = (13'(appr) * 13'd9) + 13'(sum_reg);
  assign calc_sh = calc >> 3;

  // Main FSM with fill counter, search index and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      fcnt    <= 4'd0;
      sidx    <= 4'd0;
      appr    <= '0;
      avg_reg <= '0;
      sum_reg <= '0;
      y_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (fcnt != NL) fcnt <= fcnt + 4'd1;
            // Post-increment count reaches N: the window is full.
            if (fcnt >= NL - 4'd1) state <= AVG;
          end
        end
        AVG: begin
          sum_reg <= sum_in;
          avg_reg <= avg_next;
          appr    <= '0;
          sidx    <= 4'd0;
          state   <= SEARCH;
        end
        SEARCH: begin
          if (cand_ok) appr <= rd_data;
          if (sidx == NL - 4'd1) begin
            sidx  <= 4'd0;
            state <= CALC;
          end else begin
            sidx <= sidx + 4'd1;
          end
        end
        CALC: begin
          y_reg <= calc_sh[OW-1:0];
          state <= OUT;
        end
        OUT: begin
          if (y_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_seq_ctrl.sv
// Bench for cs_seq_ctrl: emulates the window datapath and checks results against
// a queue-based reference model of the averaging rule.
module tb_cs_seq_ctrl;

  localparam int N  = 9;
  localparam int DW = 8;
  localparam int OW = 10;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          win_shift;
  logic [3:0]    rd_idx;
  logic [DW-1:0] rd_data;
  logic [SW-1:0] sum_in;
  logic          y_valid;
  logic          y_ready;
  logic [OW-1:0] y_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  // Reference model state
  logic [DW-1:0] hist[$];
  int            fill;
  logic [OW-1:0] exp_q[$];

  cs_seq_ctrl #(.N(N), .DW(DW), .OW(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .win_shift (win_shift),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .sum_in    (sum_in),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .y_data    (y_data),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- window datapath emulation ----------------
  logic [DW-1:0] win [0:N-1];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      sum_in <= '0;
    end else if (win_shift) begin
      for (int i = 0; i < N - 1; i++) win[i] <= win[i+1];
      win[N-1] <= in_data;
      sum_in   <= sum_in - SW'(win[0]) + SW'(in_data);
    end
  end
  assign rd_data = (int'(rd_idx) < N) ? win[rd_idx] : '0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_clear();
    hist.delete();
    exp_q.delete();
    fill = 0;
  endfunction

  function automatic bit model_accept(input logic [DW-1:0] v);
    int sum, avg, appr, y;
    hist.push_back(v);
    if (hist.size() > N) void'(hist.pop_front());
    if (fill < N) fill++;
    if (fill < N) return 1'b0;
    sum = 0;
    foreach (hist[i]) sum += int'(hist[i]);
    avg  = sum / 9;
    appr = 0;
    foreach (hist[i]) if (int'(hist[i]) <= avg && int'(hist[i]) > appr) appr = int'(hist[i]);
    y = (9 * appr + sum) / 8;
    exp_q.push_back(OW'(y));
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    y_ready  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    #1 check("win_shift_on_accept", win_shift, 1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int stall, input int spec_y);
    int guard = 0;
    logic [OW-1:0] exp;
    logic [OW-1:0] held;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check("in_ready_busy", in_ready, 0);
    // Offer a sample while busy: it must be ignored.
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    while (!y_valid && guard < 40) begin
      check("win_shift_ignored", win_shift, 0);
      @(negedge clk);
      guard++;
    end
    check("y_valid_seen", y_valid, 1);
    check("latency", cyc - acc_cyc, N + 2);
    exp = exp_q.pop_front();
    check("y_data_model", y_data, exp);
    if (spec_y >= 0) check("y_data_spec", y_data, spec_y);
    held = y_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_y_valid", y_valid, 1);
      check("stall_y_data", y_data, held);
      check("stall_in_ready", in_ready, 0);
      check("stall_win_shift", win_shift, 0);
    end
    in_valid = 1'b0;
    y_ready  = 1'b1;
    @(posedge clk);
    #1 y_ready = 1'b0;
    @(negedge clk);
    check("post_y_valid", y_valid, 0);
    check("post_busy", busy, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  task automatic feed(input logic [DW-1:0] v, input int stall, input int spec_y);
    send(v);
    if (model_accept(v)) begin
      wait_result(stall, spec_y);
    end else begin
      @(negedge clk);
      check("fill_busy", busy, 0);
      check("fill_y_valid", y_valid, 0);
      check("fill_in_ready", in_ready, 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    y_ready  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data", y_data, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_win_shift", win_shift, 0);
    reset = 1'b0;

    // Nine samples of 10
    for (int i = 0; i < N; i++) feed(8'd10, 0, (i == N - 1) ? 22 : -1);

    // Samples 1..9, then a 10th sample of 10
    do_reset();
    for (int i = 1; i <= N; i++) feed(DW'(i), 0, (i == N) ? 11 : -1);
    feed(8'd10, 0, 13);

    // Full-scale window
    do_reset();
    for (int i = 0; i < N; i++) feed(8'd255, 1, (i == N - 1) ? 573 : -1);

    // One large sample among zeros, consumer stalls 5 cycles
    do_reset();
    for (int i = 0; i < N - 1; i++) feed(8'd0, 0, -1);
    feed(8'd90, 5, 11);

    // Reset pulse in the middle of SEARCH
    do_reset();
    for (int i = 0; i < N; i++) begin
      send(DW'(i + 3));
      void'(model_accept(DW'(i + 3)));
    end
    guard = 0;
    @(negedge clk);
    while (rd_idx != 4'd4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("search_rd_idx4", rd_idx, 4);
    #2 reset = 1'b1;
    #1;
    check("midrst_y_valid", y_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_rd_idx", rd_idx, 0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) feed(DW'($urandom_range(0, 40)), 0, -1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 1) == 0) feed(DW'($urandom), $urandom_range(0, 3), -1);
      else feed(DW'($urandom_range(0, 20)), $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
